// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit: iterative RV32M multiply/divide unit; define MULDIV_FAST_MUL_EN for a single-cycle multiplier
module riscv_muldiv_unit #(
  parameter int XLEN = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_rd,
  output logic             busy
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*XLEN-1:0] acc, acc_n, prod;
  logic [XLEN-1:0] b, a_mag, b_mag, quo, rem, calc_res, spec_res, fast_res, sub;
  logic [XLEN:0] mul_sum;
  logic [2:0] f3;
  logic qneg, rneg, s1, s2, n1, n2, dz, ovf, special, fast, accept, ge;
  always_comb begin
    s1 = in_funct3[2] ? !in_funct3[0] : (in_funct3[1:0] == 2'b01 || in_funct3[1:0] == 2'b10);
    s2 = in_funct3[2] ? !in_funct3[0] : (in_funct3[1:0] == 2'b01);
    n1 = s1 && in_rs1[XLEN-1];
    n2 = s2 && in_rs2[XLEN-1];
    a_mag = n1 ? -in_rs1 : in_rs1;
    b_mag = n2 ? -in_rs2 : in_rs2;
    dz = in_rs2 == '0;
    ovf = s2 && in_funct3[2] && in_rs1 == {1'b1, {(XLEN-1){1'b0}}} && in_rs2 == '1;
    special = in_funct3[2] && (dz || ovf);
    spec_res = dz ? (in_funct3[1] ? in_rs1 : '1) : (in_funct3[1] ? '0 : in_rs1);
    accept = in_valid && state == IDLE && !flush;
  end
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fprod;
  assign fprod = {{XLEN{n1}}, in_rs1} * {{XLEN{n2}}, in_rs2};
  assign fast = !in_funct3[2];
  assign fast_res = in_funct3[1:0] == 2'b00 ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`else
  assign fast = 1'b0;
  assign fast_res = '0;
`endif
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b} : '0);
    ge = acc[2*XLEN-1:XLEN-1] >= {1'b0, b};
    sub = acc[2*XLEN-2:XLEN-1] - b;
    acc_n = f3[2] ? (ge ? {sub, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0}) : {mul_sum, acc[XLEN-1:1]};
    prod = qneg ? -acc_n : acc_n;
    quo = qneg ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
    rem = rneg ? -acc_n[2*XLEN-1:XLEN] : acc_n[2*XLEN-1:XLEN];
    calc_res = f3[2] ? (f3[1] ? rem : quo) : (f3[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  always_comb begin
    state_n = flush ? IDLE
            : state == IDLE ? (in_valid ? (special || fast ? DONE : CALC) : IDLE)
            : state == CALC ? (cnt == '0 ? DONE : CALC)
            : out_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      f3 <= '0;
      cnt <= '0;
      acc <= '0;
      b <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      out_result <= '0;
      out_rd <= '0;
    end else if (accept) begin
      f3 <= in_funct3;
      out_rd <= in_rd;
      cnt <= CW'(XLEN-1);
      acc <= {{XLEN{1'b0}}, a_mag};
      b <= b_mag;
      qneg <= n1 ^ n2;
      rneg <= n1;
      if (special || fast) out_result <= special ? spec_res : fast_res;
    end else if (state == CALC && !flush) begin
      acc <= acc_n;
      cnt <= cnt - 1'b1;
      if (cnt == '0) out_result <= calc_res;
    end
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
endmodule

// File: doc/riscv_muldiv_unit.md
# riscv_muldiv_unit

Iterative multiply/divide execution unit implementing the RV32M operations (funct7 = 7'b0000001 under OP_REG). The unit widens the base integer ALU to 2·XLEN products and signed/unsigned division. It sits beside the EX-stage ALU and is issued through a valid/ready handshake. The pipeline stalls on `in_ready` low and flushes it on a taken branch or jump.

## Interface
- `XLEN`, 32: operand/result width; must be even and ≥ 8.
- `TAG_W`, 5: destination-register tag width.

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: kill any in-flight or held operation.
- `in_valid` in 1: request valid.
- `in_ready` out 1: unit can accept a request.
- `in_funct3` in 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `in_rs1` in XLEN: operand A (multiplicand/dividend).
- `in_rs2` in XLEN: operand B (multiplier/divisor).
- `in_rd` in TAG_W: destination tag, returned unchanged.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out_result` out XLEN: result.
- `out_rd` out TAG_W: tag of result.
- `busy` out 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: `in_ready`=1. Accept occurs when `in_valid`&`in_ready`&!`flush` at a rising edge. On accept, latch funct3, rd, operand magnitudes and result-sign flags.
  - Special divide case goes to DONE.
  - Otherwise goes to CALC and the step counter loads XLEN-1.
- CALC: one radix-2 step per clock.
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring shift-subtract on a remainder/quotient pair.
  - Counter decrements each step. At 0, apply sign correction and go to DONE.
- DONE: `out_valid`=1. `out_result`/`out_rd` hold stable until `out_valid`&`out_ready`, then go to IDLE.
- Sign rules:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: unsigned.
  - MUL: low XLEN bits of the product.
  - MULH*: high XLEN bits.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
- Special divide cases (no CALC):
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return rs1.
  - Signed overflow (rs1 = 1 followed by XLEN-1 zeros, rs2 = all ones): DIV returns rs1; REM returns 0.
- Tag rd = 0 is computed normally. Writeback discards it.
- `flush` in any state: next state IDLE, `out_valid`=0, result dropped. `flush` and `in_valid` in the same cycle: no accept.
- `rst` overrides `flush` and everything else.

## Timing
- Reset values:
  - `out_valid`=0, `out_result`=0, `out_rd`=0, `busy`=0.
  - State is IDLE, so `in_ready`=1 in the first cycle after reset.
  - Reset mid-operation discards the operation.
- `in_ready` is combinational from state only. There is no same-cycle pass-through from a DONE handshake to a new accept: after a result is taken, `in_ready` rises the next cycle.
- Latency counts from the accepting edge to the first cycle with `out_valid`=1:
  - Iterative ops: XLEN+1 clocks (33 at XLEN=32).
  - Special divide cases: 1 clock.
- Throughput: one operation in flight. The minimum issue interval for iterative ops is XLEN+2 clocks with `out_ready` held high.
- `busy` is high from the cycle after accept until the cycle after the result handshake or flush.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: MUL/MULH/MULHSU/MULHU compute with a single-cycle 2·XLEN combinational multiplier. Accept goes directly to DONE, giving latency 1 clock. Divide is unchanged.
- Not defined: all multiplies use the iterative CALC path with latency XLEN+1. No hardware multiplier is inferred.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD, rd=5 → `out_result`=0xFFFFFFEB and `out_rd`=5. `out_valid` rises 33 clocks after accept, or 1 clock with `MULDIV_FAST_MUL_EN`.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- Divides:
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9%2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- Special cases, each with `out_valid` 1 clock after accept:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE. `out_valid`, `out_result` and `out_rd` must stay stable and `in_ready`=0 throughout. After `out_ready`=1, `in_ready`=1 on the following cycle.
- Abort: assert `flush` in the 10th CALC cycle of a DIVU, with `in_valid`=1 in the same cycle.
  - Required: no `out_valid`, no accept, `in_ready`=1 the next cycle, `busy`=0.
  - Repeat with `rst` instead of `flush`: all outputs return to their reset values.
